alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised, handshaked successor to the datapath ALU.
- Single-cycle ops are AND, OR, ADD, SUB, shifts, compares and XOR; they finish in one registered cycle.
- Iterative shift-add MUL and restoring DIVU/REMU run one bit per cycle.
- Sits between the decode/issue stage and writeback.
- Issue stalls on in_ready; writeback consumes on out_valid/out_ready.

Parameters:
- XLEN, 32, operand/result width (power of two, >= 8).
- SHW, $clog2(XLEN), shift-amount width (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept a request
- alu_control  in  4  operation code
- in1  in  XLEN  operand A
- in2  in  XLEN  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- alu_result  out  XLEN  registered result
- zero_flag  out  1  alu_result == 0
- illegal_op  out  1  alu_control was an undefined code

Behaviour:
- Op codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SUB, 0101 SRL, 0110 MUL (low XLEN bits), 0111 XOR.
  - 1000 SLTU (unsigned), 1001 SLT (signed), 1010 SRA, 1011 DIVU, 1100 REMU.
  - 1101–1111 undefined.
- Shift amount is in2[SHW-1:0]; upper bits are ignored. ADD/SUB wrap modulo 2^XLEN.
- State machine: IDLE, BUSY, DONE.
- in_ready = (state == IDLE). A transfer occurs when in_valid && in_ready.
- IDLE, accept, single-cycle or undefined op:
  - Result computed from the inputs and registered.
  - Next state DONE, so out_valid rises the cycle after accept (latency 1).
- IDLE, accept, MUL/DIVU/REMU:
  - Latch operands and op; load step counter with XLEN; next state BUSY.
- BUSY:
  - One shift-add or restoring-subtract step per cycle; counter decrements.
  - On the step where counter == 1, the final result is registered and the next state is DONE.
  - Latency: out_valid asserts XLEN+1 cycles after accept (33 for XLEN=32).
  - in_valid is ignored; in_ready = 0.
- DONE:
  - out_valid = 1; alu_result, zero_flag and illegal_op are held stable.
  - When out_ready = 1, next state is IDLE. No new request is accepted in the same cycle; single-cycle throughput is 1 op per 2 cycles.
  - If out_ready = 0, the block stays in DONE indefinitely with outputs unchanged.
- Divide by zero (in2 == 0): DIVU result is all ones; REMU result is in1. Latency is still XLEN+1, with no early exit.
- Undefined code: alu_result = 0, zero_flag = 1, illegal_op = 1. Latency 1.
- zero_flag and illegal_op are registered together with alu_result. They are valid only while out_valid = 1 and hold their value otherwise.
- Reset values: state IDLE, out_valid 0, alu_result 0, zero_flag 0, illegal_op 0, counter 0, operand registers 0.
- Reset asserted in BUSY or DONE aborts the op: the result is discarded, no out_valid pulse follows, and in_ready = 1 on the first cycle after reset deasserts.
- Inputs are sampled only on the accept cycle. Operand changes afterwards have no effect.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit opcode localparams (OP_AND … OP_REMU);
  - the state enum (IDLE/BUSY/DONE);
  - a helper function is_multicycle(op).
- Sub-module alu_muldiv_iter holds the iterative MUL/DIVU/REMU datapath:
  - inputs: start, op, a, b;
  - outputs: done, result;
  - it owns the step counter.
- The top module keeps the FSM, the handshake and the combinational single-cycle ops.

Test Plan (XLEN=32):
- Reset, then ADD 0x0000_0005 + 0xFFFF_FFFB → out_valid on cycle 1, alu_result 0, zero_flag 1, illegal_op 0.
- SLT 0xFFFF_FFFF vs 1 → result 1. SLTU with the same operands → result 0. SRA 0x8000_0000 by in2 = 0x24 → 0xF800_0000 (amount 4).
- MUL 0x0001_0003 × 0x0002_0005 → out_valid exactly 33 cycles after accept, result 0x000B_000F. in_ready stays 0 throughout, and in_valid pulses during BUSY are ignored.
- DIVU 100 / 7 → 14. REMU 100 / 7 → 2. DIVU x / 0 → 0xFFFF_FFFF. REMU 0x1234 / 0 → 0x1234.
- Backpressure: hold out_ready = 0 for 10 cycles after an XOR → out_valid and alu_result stay stable and in_ready stays 0. Raise out_ready → IDLE next cycle.
- Reset at cycle 10 of a MUL → no out_valid pulse afterwards. An AND 0xF0F0 & 0x0FF0 issued immediately after reset → 0x00F0. An undefined op 1110 → result 0, zero_flag 1, illegal_op 1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and op classification shared by the multicycle ALU
package alu_pkg;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic logic is_multicycle(input logic [3:0] op);
    return op inside {OP_MUL, OP_DIVU, OP_REMU};
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle shift-add multiply and restoring unsigned divide
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN) + 1;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_op;
  logic [XLEN-1:0] r_x, r_y, r_acc;
  logic [XLEN-1:0] w_mul_acc, w_rem_n, w_q_n;
  logic [XLEN:0]   w_rem_sh, w_diff;
  logic            w_ge;
  // r_x: multiplicand (MUL) or dividend/quotient shifter (DIV); r_acc: product or partial remainder
  assign w_mul_acc = r_acc + (r_y[0] ? r_x : '0);
  assign w_rem_sh  = {r_acc, r_x[XLEN-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_y};
  assign w_ge      = ~w_diff[XLEN];
  assign w_rem_n   = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_q_n     = {r_x[XLEN-2:0], w_ge};
  assign done      = r_cnt == CW'(1);
  assign result    = r_op == OP_MUL ? w_mul_acc : r_op == OP_DIVU ? w_q_n : w_rem_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
    end else if (start) begin
      r_cnt <= CW'(XLEN);
      r_op  <= op;
      r_x   <= a;
      r_y   <= b;
      r_acc <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_op == OP_MUL) begin
        r_acc <= w_mul_acc;
        r_x   <= r_x << 1;
        r_y   <= r_y >> 1;
      end else begin
        r_acc <= w_rem_n;
        r_x   <= w_q_n;
      end
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU, single-cycle logic/arith ops plus iterative MUL/DIVU/REMU
module alu_multicycle
  import alu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero_flag,
  output logic            illegal_op
);
  state_t          r_state;
  logic            r_out_valid, r_zero, r_illegal;
  logic [XLEN-1:0] r_result, w_res, w_md_result;
  logic [SHW-1:0]  w_sh;
  logic            w_start, w_md_done, w_illegal;
  assign w_sh      = in2[SHW-1:0];
  assign in_ready  = r_state == IDLE;
  assign w_start   = in_ready && in_valid && is_multicycle(alu_control);
  assign w_illegal = alu_control > OP_REMU;
  always_comb begin
    w_res = '0;
    case (alu_control)
      OP_AND:  w_res = in1 & in2;
      OP_OR:   w_res = in1 | in2;
      OP_ADD:  w_res = in1 + in2;
      OP_SLL:  w_res = in1 << w_sh;
      OP_SUB:  w_res = in1 - in2;
      OP_SRL:  w_res = in1 >> w_sh;
      OP_XOR:  w_res = in1 ^ in2;
      OP_SLTU: w_res = {{(XLEN-1){1'b0}}, in1 < in2};
      OP_SLT:  w_res = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
      OP_SRA:  w_res = $signed(in1) >>> w_sh;
      default: w_res = '0;
    endcase
  end
  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (w_start),
    .op     (alu_control),
    .a      (in1),
    .b      (in2),
    .done   (w_md_done),
    .result (w_md_result)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          if (is_multicycle(alu_control)) r_state <= BUSY;
          else begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_zero      <= w_res == '0;
            r_illegal   <= w_illegal;
          end
        end
        BUSY: if (w_md_done) begin
          r_state     <= DONE;
          r_out_valid <= 1'b1;
          r_result    <= w_md_result;
          r_zero      <= w_md_result == '0;
          r_illegal   <= 1'b0;
        end
        DONE: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign zero_flag  = r_zero;
  assign illegal_op = r_illegal;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and randomized checks of alu_multicycle against an arithmetic model
module tb_alu_multicycle;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, zero_flag, illegal_op;
  logic [3:0]  alu_control;
  logic [31:0] in1, in2, alu_result;
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  alu_multicycle #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .in1         (in1),
    .in2         (in2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_result  (alu_result),
    .zero_flag   (zero_flag),
    .illegal_op  (illegal_op)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a << b[4:0];
      4'd4:  return a - b;
      4'd5:  return a >> b[4:0];
      4'd6:  return p[31:0];
      4'd7:  return a ^ b;
      4'd8:  return (a < b) ? 32'd1 : 32'd0;
      4'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: return $signed(a) >>> b[4:0];
      4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction
  task automatic scramble();
    alu_control = 4'($urandom);
    in1 = $urandom;
    in2 = $urandom;
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] want_r;
    int          lat, want_lat;
    bit          rdy_ok;
    want_r   = ref_alu(op, a, b);
    want_lat = (op == 4'd6 || op == 4'd11 || op == 4'd12) ? 33 : 1;
    for (int i = 0; i < 5 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; alu_control = op; in1 = a; in2 = b;
    @(posedge clk); #1;
    lat = 1;
    rdy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_ok = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      scramble();
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    scramble();
    chk("latency", 32'(lat), 32'(want_lat));
    chk("in_ready_busy", 32'(rdy_ok), 32'd1);
    chk("result", alu_result, want_r);
    chk("zero_flag", 32'(zero_flag), (op > 4'd12 || want_r == 0) ? 32'd1 : 32'd0);
    chk("illegal_op", 32'(illegal_op), (op > 4'd12) ? 32'd1 : 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", alu_result, want_r);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_ready", 32'(in_ready), 32'd1);
  endtask
  task automatic reset_mid_mul();
    in_valid = 1'b1; alu_control = 4'd6; in1 = 32'h0001_0003; in2 = 32'h0002_0005;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_valid", 32'(out_valid), 32'd0);
  endtask
  initial begin
    bit     seen;
    logic [3:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = '0; in1 = '0; in2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", alu_result, 32'd0);
    chk("rst_zero", 32'(zero_flag), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    issue(4'd2, 32'h0000_0005, 32'hFFFF_FFFB, 0);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 0);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 0);
    issue(4'd10, 32'h8000_0000, 32'h24, 0);
    issue(4'd6, 32'h0001_0003, 32'h0002_0005, 0);
    issue(4'd11, 32'd100, 32'd7, 0);
    issue(4'd12, 32'd100, 32'd7, 0);
    issue(4'd11, $urandom, 32'd0, 0);
    issue(4'd12, 32'h1234, 32'd0, 0);
    issue(4'd7, $urandom, $urandom, 10);
    reset_mid_mul();
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);
    reset_mid_mul();
    issue(4'd0, 32'h0000_F0F0, 32'h0000_0FF0, 0);
    issue(4'd14, $urandom, $urandom, 2);
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      issue(op, a, b, $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
